// File: rtl/vermitime_multi_pkg.sv
// Shared types and address-map constants for the multi-channel Vermitime timer.
package vermitime_multi_pkg;

  typedef enum logic [2:0] {
    CONTROL         = 3'd0,
    STATUS          = 3'd1,
    REFILL          = 3'd2,
    COUNT           = 3'd3,
    CHANNEL_REG_NUM = 3'd4
  } channel_reg_e;

  // Global registers sit right after the last channel block.
  localparam int PRESCALE_OFFSET = 0;
  localparam int PENDING_OFFSET  = 1;

  typedef struct packed {
    logic irq_enable;
    logic cyclic_mode;
    logic count_enable;
  } control_reg_t;

  typedef struct packed {
    logic event_flag;
  } status_reg_t;

  function automatic int local_address_width(input int channels);
    return $clog2(int'(CHANNEL_REG_NUM) * channels + 2);
  endfunction

endpackage

// File: rtl/vermitime_channel.sv
// One timer channel: control/status/refill/count registers and its irq request.
module vermitime_channel
  import vermitime_multi_pkg::*;
#(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic                           i_tick,
  input  logic                           i_control_we,
  input  logic                           i_status_we,
  input  logic                           i_refill_we,
  input  logic [(COUNT_WIDTH+7)/8-1:0]   i_refill_be,
  input  logic [COUNT_WIDTH-1:0]         i_wdata,
  output logic [31:0]                    o_control,
  output logic [31:0]                    o_status,
  output logic [31:0]                    o_refill,
  output logic [31:0]                    o_count,
  output logic                           o_irq_req
);

  control_reg_t           r_control;
  status_reg_t            r_status;
  logic [COUNT_WIDTH-1:0] r_refill;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [COUNT_WIDTH-1:0] w_refill_new;
  logic                   w_run;
  logic                   w_rollover;

  assign w_run      = i_tick & r_control.count_enable;
  assign w_rollover = w_run & (r_count == '0);

  always_comb begin
    w_refill_new = r_refill;
    for (int i = 0; i < COUNT_WIDTH; i++) begin
      if (i_refill_be[i/8]) w_refill_new[i] = i_wdata[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_refill <= '0;
    else if (i_refill_we) r_refill <= w_refill_new;
  end

  // A refill write reloads the counter and wins over any tick activity.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_refill_we) begin
      r_count <= w_refill_new;
    end else if (w_run) begin
      if (r_count != '0) r_count <= r_count - 1'b1;
      else if (r_control.cyclic_mode) r_count <= r_refill;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_control <= '0;
    else if (i_control_we) r_control <= control_reg_t'(i_wdata[2:0]);
    else if (w_rollover && !r_control.cyclic_mode) r_control.count_enable <= 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_status <= '0;
    else if (w_rollover) r_status.event_flag <= 1'b1;
    else if (i_status_we) r_status.event_flag <= i_wdata[0];
  end

  assign o_control = {29'b0, r_control};
  assign o_status  = {31'b0, r_status};
  assign o_refill  = 32'(r_refill);
  assign o_count   = 32'(r_count);
  assign o_irq_req = r_status.event_flag & r_control.irq_enable;

endmodule

// File: rtl/vermitime_multi.sv
// Multi-channel Vermitime timer: shared prescaler, bus decode, readback mux and irq summary.
module vermitime_multi
  import vermitime_multi_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int COUNT_WIDTH    = 32,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid,
  output logic        ready,
  input  logic [31:0] address,
  input  logic [3:0]  wstrobe,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int LAW      = local_address_width(CHANNELS);
  localparam int CH_WORDS = int'(CHANNEL_REG_NUM) * CHANNELS;
  localparam int BYTES    = (COUNT_WIDTH + 7) / 8;
  localparam logic [LAW-1:0] PRESCALE_WORD = LAW'(CH_WORDS + PRESCALE_OFFSET);
  localparam logic [LAW-1:0] PENDING_WORD  = LAW'(CH_WORDS + PENDING_OFFSET);

  logic [LAW-1:0]            w_word;
  logic                      w_write;
  logic                      w_unused_addr;
  logic                      w_tick;
  logic                      w_prescale_we;
  logic [PRESCALE_WIDTH-1:0] w_prescale_new;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [PRESCALE_WIDTH-1:0] r_divider;
  logic [31:0]               w_ch_rd [CH_WORDS];
  logic [CHANNELS-1:0]       w_pending;

  assign ready         = valid;
  assign w_word        = address[2 +: LAW];
  assign w_write       = valid & (|wstrobe);
  assign w_unused_addr = ^{address[1:0], address[31:2+LAW]};

  assign w_prescale_we = w_write && (w_word == PRESCALE_WORD);
  assign w_tick        = (r_divider == r_prescale);

  always_comb begin
    w_prescale_new = r_prescale;
    for (int i = 0; i < PRESCALE_WIDTH; i++) begin
      if (wstrobe[i/8]) w_prescale_new[i] = wdata[i];
    end
  end

  // Writing PRESCALE restarts the divider so the new period starts cleanly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prescale <= '0;
      r_divider  <= '0;
    end else if (w_prescale_we) begin
      r_prescale <= w_prescale_new;
      r_divider  <= '0;
    end else if (w_tick) begin
      r_divider  <= '0;
    end else begin
      r_divider  <= r_divider + 1'b1;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic w_sel;
    assign w_sel = w_write && (w_word[LAW-1:2] == (LAW-2)'(c));

    vermitime_channel #(
      .COUNT_WIDTH(COUNT_WIDTH)
    ) u_channel (
      .i_clk       (clk),
      .i_reset_n   (reset_n),
      .i_tick      (w_tick),
      .i_control_we(w_sel && (w_word[1:0] == 2'(CONTROL)) && wstrobe[0]),
      .i_status_we (w_sel && (w_word[1:0] == 2'(STATUS)) && wstrobe[0]),
      .i_refill_we (w_sel && (w_word[1:0] == 2'(REFILL))),
      .i_refill_be (wstrobe[BYTES-1:0]),
      .i_wdata     (wdata[COUNT_WIDTH-1:0]),
      .o_control   (w_ch_rd[4*c + int'(CONTROL)]),
      .o_status    (w_ch_rd[4*c + int'(STATUS)]),
      .o_refill    (w_ch_rd[4*c + int'(REFILL)]),
      .o_count     (w_ch_rd[4*c + int'(COUNT)]),
      .o_irq_req   (w_pending[c])
    );
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < CH_WORDS; i++) begin
      if (w_word == LAW'(i)) rdata = w_ch_rd[i];
    end
    if (w_word == PRESCALE_WORD) rdata = 32'(r_prescale);
    if (w_word == PENDING_WORD)  rdata = 32'(w_pending);
  end

  assign irq = |w_pending;

endmodule

// File: tb/tb_vermitime_multi.sv
// Bench for vermitime_multi: directed scenarios plus randomized traffic against a behavioural model.
module tb_vermitime_multi;

  localparam int NCH    = 4;
  localparam int LAW    = $clog2(4*NCH + 2);
  localparam int W_PRE  = 4*NCH;
  localparam int W_PEND = 4*NCH + 1;
  localparam logic [31:0] PRE_MASK = 32'h0000_FFFF;

  logic        clk;
  logic        reset_n;
  logic        valid;
  logic        ready;
  logic [31:0] address;
  logic [3:0]  wstrobe;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  vermitime_multi #(
    .CHANNELS(NCH), .COUNT_WIDTH(32), .PRESCALE_WIDTH(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .valid(valid), .ready(ready),
    .address(address), .wstrobe(wstrobe), .wdata(wdata),
    .rdata(rdata), .irq(irq)
  );

  int n_tests;
  int n_fail;
  int cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] refill;
    logic [31:0] count;
    logic        ie;
    logic        cyc;
    logic        en;
    logic        flag;
  } ch_t;

  ch_t         m_ch [NCH];
  logic [31:0] m_pre;
  logic [31:0] m_div;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic bit wr_hit(input int w);
    return valid && (wstrobe != 4'b0) && (int'(address[2 +: LAW]) == w);
  endfunction

  function automatic ch_t ch_next(input ch_t s, input logic tk, input logic wc, input logic ws,
                                  input logic wrf, input logic [3:0] st, input logic [31:0] d);
    ch_t  n;
    logic roll;
    n = s;
    roll = tk && s.en && (s.count == 32'd0);
    if (tk && s.en) begin
      if (s.count != 32'd0) n.count = s.count - 32'd1;
      else if (s.cyc)       n.count = s.refill;
      else                  n.en = 1'b0;
    end
    if (roll)             n.flag = 1'b1;
    else if (ws && st[0]) n.flag = d[0];
    if (wc && st[0]) {n.ie, n.cyc, n.en} = d[2:0];
    if (wrf) begin
      n.refill = merge(s.refill, d, st);
      n.count  = n.refill;
    end
    return n;
  endfunction

  function automatic logic [31:0] m_pend();
    logic [31:0] p;
    p = 32'd0;
    for (int c = 0; c < NCH; c++) p[c] = m_ch[c].flag & m_ch[c].ie;
    return p;
  endfunction

  function automatic logic [31:0] m_read(input int w);
    ch_t s;
    if (w < 4*NCH) begin
      s = m_ch[w/4];
      case (w % 4)
        0:       return {29'b0, s.ie, s.cyc, s.en};
        1:       return {31'b0, s.flag};
        2:       return s.refill;
        default: return s.count;
      endcase
    end
    if (w == W_PRE)  return m_pre;
    if (w == W_PEND) return m_pend();
    return 32'd0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) m_ch[c] <= '0;
      m_pre <= 32'd0;
      m_div <= 32'd0;
    end else begin
      for (int c = 0; c < NCH; c++)
        m_ch[c] <= ch_next(m_ch[c], m_div == m_pre, wr_hit(4*c), wr_hit(4*c+1),
                           wr_hit(4*c+2), wstrobe, wdata);
      if (wr_hit(W_PRE)) begin
        m_pre <= merge(m_pre, wdata, wstrobe) & PRE_MASK;
        m_div <= 32'd0;
      end else if (m_div == m_pre) begin
        m_div <= 32'd0;
      end else begin
        m_div <= m_div + 32'd1;
      end
    end
  end

  // ---------------- bus helpers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int w, input logic [3:0] s, input logic [31:0] d);
    valid   = 1'b1;
    address = 32'(w) << 2;
    wstrobe = s;
    wdata   = d;
    @(posedge clk);
    #1;
    valid   = 1'b0;
    wstrobe = 4'b0;
  endtask

  task automatic rd(input int w, output logic [31:0] d);
    valid   = 1'b1;
    address = 32'(w) << 2;
    wstrobe = 4'b0;
    #1;
    d = rdata;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d;
    valid = 1'b0;
    #1;
    n_tests++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_idle: got %b, expected 0", ready); end
    for (int w = 0; w <= W_PEND + 1; w++) begin
      rd(w, d);
      n_tests++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL reset_word%0d: got %h, expected 0", w, d); end
      n_tests++;
      if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_w%0d: got %b, expected 1", w, ready); end
      if (w % 4 == 3) idle(1);
    end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b, expected 0", irq); end
  endtask

  task automatic test_cyclic();
    logic [31:0] d;
    wr(2, 4'hF, 32'd5);
    wr(W_PRE, 4'hF, 32'd0);
    wr(0, 4'h1, 32'd7);
    rd(3, d);
    n_tests++;
    if (d !== 32'd5) begin n_fail++; $display("FAIL cyc_count_start: got %0d, expected 5", d); end
    for (int k = 4; k >= 0; k--) begin
      idle(1);
      rd(3, d);
      n_tests++;
      if (d !== 32'(k)) begin n_fail++; $display("FAIL cyc_count_step: got %0d, expected %0d", d, k); end
    end
    idle(1);
    rd(3, d);
    n_tests++;
    if (d !== 32'd5) begin n_fail++; $display("FAIL cyc_reload: got %0d, expected 5", d); end
    rd(1, d);
    n_tests++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL cyc_flag: got %0d, expected 1", d); end
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL cyc_irq: got %b, expected 1", irq); end
    rd(W_PEND, d);
    n_tests++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL cyc_pending: got %h, expected 1", d); end
    wr(1, 4'h1, 32'd0);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL cyc_irq_clear: got %b, expected 0", irq); end
    wr(0, 4'h1, 32'd0);
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    wr(10, 4'hF, 32'd3);
    wr(8, 4'h1, 32'd1);
    idle(4);
    rd(11, d);
    n_tests++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL os_count: got %0d, expected 0", d); end
    rd(9, d);
    n_tests++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL os_flag: got %0d, expected 1", d); end
    rd(8, d);
    n_tests++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL os_autoclear: got %0d, expected 0", d); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL os_irq: got %b, expected 0", irq); end
    idle(10);
    rd(11, d);
    n_tests++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL os_hold: got %0d, expected 0", d); end
  endtask

  task automatic test_prescale();
    logic [31:0] d;
    bit found;
    int t0;
    wr(W_PRE, 4'hF, 32'd3);
    wr(6, 4'hF, 32'd2);
    wr(4, 4'h1, 32'd3);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      idle(1);
      rd(5, d);
      if (d[0]) found = 1;
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL ps_first_event: got none, expected event within 40 cycles"); end
    t0 = cyc;
    wr(5, 4'h1, 32'd0);
    idle(2);
    rd(7, d);
    n_tests++;
    if (d !== 32'd2) begin n_fail++; $display("FAIL ps_hold3: got %0d, expected 2", d); end
    idle(1);
    rd(7, d);
    n_tests++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL ps_dec4: got %0d, expected 1", d); end
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      idle(1);
      rd(5, d);
      if (d[0]) found = 1;
    end
    n_tests++;
    if (!found || (cyc - t0) != 12) begin
      n_fail++; $display("FAIL ps_event_gap: got %0d, expected 12", cyc - t0);
    end
    idle(1);
    wr(W_PRE, 4'hF, 32'd3);
    idle(3);
    rd(7, d);
    n_tests++;
    if (d !== 32'd2) begin n_fail++; $display("FAIL ps_restart_hold: got %0d, expected 2", d); end
    idle(1);
    rd(7, d);
    n_tests++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL ps_restart_tick: got %0d, expected 1", d); end
    wr(4, 4'h1, 32'd0);
    wr(W_PRE, 4'hF, 32'd0);
    wr(5, 4'h1, 32'd0);
  endtask

  task automatic test_collisions();
    logic [31:0] d;
    wr(14, 4'hF, 32'd2);
    wr(12, 4'h1, 32'd3);
    idle(2);
    wr(13, 4'h1, 32'd0);
    rd(13, d);
    n_tests++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL col_status: got %0d, expected 1", d); end
    rd(15, d);
    n_tests++;
    if (d !== 32'd2) begin n_fail++; $display("FAIL col_status_reload: got %0d, expected 2", d); end
    wr(12, 4'h1, 32'd0);
    wr(10, 4'hF, 32'd1);
    wr(8, 4'h1, 32'd1);
    idle(1);
    wr(8, 4'h1, 32'd1);
    rd(8, d);
    n_tests++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL col_control: got %0d, expected 1", d); end
    idle(1);
    rd(8, d);
    n_tests++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL col_control_after: got %0d, expected 0", d); end
    wr(2, 4'hF, 32'h1200);
    wr(2, 4'b0001, 32'hAB);
    rd(2, d);
    n_tests++;
    if (d !== 32'h12AB) begin n_fail++; $display("FAIL col_refill_be: got %h, expected 12ab", d); end
    rd(3, d);
    n_tests++;
    if (d !== 32'h12AB) begin n_fail++; $display("FAIL col_count_be: got %h, expected 12ab", d); end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [31:0] e;
    int w;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        w = $urandom_range(0, W_PEND + 3);
        d = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 7));
        wr(w, 4'($urandom_range(0, 15)), d);
      end else begin
        idle(1);
      end
      for (int k = 0; k < 3; k++) begin
        w = $urandom_range(0, W_PEND + 2);
        rd(w, d);
        e = m_read(w);
        n_tests++;
        if (d !== e) begin n_fail++; $display("FAIL rnd_word%0d: got %h, expected %h", w, d, e); end
      end
      n_tests++;
      if (irq !== (m_pend() != 32'd0)) begin
        n_fail++; $display("FAIL rnd_irq: got %b, expected %b", irq, m_pend() != 32'd0);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    wr(W_PRE, 4'hF, 32'd0);
    wr(2, 4'hF, 32'd1);
    wr(0, 4'h1, 32'd7);
    idle(3);
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL ar_irq_before: got %b, expected 1", irq); end
    #3;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL ar_irq: got %b, expected 0", irq); end
    rd(3, d);
    n_tests++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL ar_count: got %h, expected 0", d); end
    rd(0, d);
    n_tests++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL ar_control: got %h, expected 0", d); end
    rd(2, d);
    n_tests++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL ar_refill: got %h, expected 0", d); end
    @(negedge clk);
    reset_n = 1'b1;
    idle(3);
    rd(3, d);
    n_tests++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL ar_idle_count: got %h, expected 0", d); end
    wr(2, 4'hF, 32'd3);
    wr(0, 4'h1, 32'd1);
    idle(1);
    rd(3, d);
    n_tests++;
    if (d !== 32'd2) begin n_fail++; $display("FAIL ar_resume: got %0d, expected 2", d); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    valid   = 1'b0;
    address = 32'd0;
    wstrobe = 4'b0;
    wdata   = 32'd0;
    reset_n = 1'b0;
    #12 reset_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_cyclic();
    test_oneshot();
    test_prescale();
    test_collisions();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
